nios_wallet_mem_stream_reader: RTL and testbench

Read-side DMA stage that sits directly on the Avalon-MM s1 port of the 6500×32 on-chip program/data RAM. Given a base word address and length, it issues back-to-back single-word reads, absorbs the RAM's one-cycle read latency, and delivers the words as a valid/ready stream, e.g. message blocks for the wallet's hash core. A small FIFO provides backpressure decoupling, so the RAM read is never stalled mid-flight.

---
 rtl/nios_wallet_mem_reader_pkg.sv | 12 +
 rtl/nios_wallet_sync_fifo.sv | 43 ++++
 rtl/nios_wallet_mem_stream_reader.sv | 109 ++++++++++
 tb/tb_nios_wallet_mem_stream_reader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/nios_wallet_mem_reader_pkg.sv
// nios_wallet_mem_reader_pkg: RAM geometry and reader FSM encoding shared with the RAM wrapper
package nios_wallet_mem_reader_pkg;
  localparam int RAM_DEPTH  = 6500;
  localparam int RAM_ADDR_W = 13;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_LEN_W  = 14;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_FIN   = 2'd3;
endpackage

// File: rtl/nios_wallet_sync_fifo.sv
// nios_wallet_sync_fifo: small synchronous FIFO with occupancy count and synchronous flush
module nios_wallet_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_pop   = i_pop && r_count != '0;
  assign o_valid = r_count != '0;
  assign o_count = r_count;
  // data is forced to zero while empty so the stream port idles at zero
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  always_ff @(posedge i_clk)
    if (i_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= inc(r_wr);
      if (w_pop) r_rd <= inc(r_rd);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/nios_wallet_mem_stream_reader.sv
// nios_wallet_mem_stream_reader: streams a word range out of the on-chip RAM as valid/ready data
module nios_wallet_mem_stream_reader
  import nios_wallet_mem_reader_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int DEPTH      = RAM_DEPTH,
  parameter int LEN_W      = RAM_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_num_words,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_chipselect,
  output logic              o_mem_write,
  output logic [3:0]        o_mem_byteenable,
  output logic              o_mem_clken,
  input  logic [DATA_W-1:0] i_mem_readdata,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  output logic              o_out_last,
  input  logic              i_out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0] r_left;
  logic r_cs, r_cs_last, r_fly, r_fly_last, r_err;
  logic [CW-1:0] w_count;
  logic w_pop, w_flush, w_bad, w_credit;
  int w_occ;
  assign w_pop   = o_out_valid && i_out_ready;
  assign w_flush = i_abort && r_state != S_IDLE;
  assign w_bad   = (LEN_W+1)'(i_base_addr) + (LEN_W+1)'(i_num_words) > (LEN_W+1)'(DEPTH);
  // occupancy next cycle; the read issued this cycle is still in flight then
  assign w_occ    = int'(w_count) + int'(r_fly) - int'(w_pop);
  assign w_credit = w_occ + int'(r_cs) + 1 <= FIFO_DEPTH;
  assign o_busy           = r_state != S_IDLE;
  assign o_done           = r_state == S_FIN;
  assign o_err            = o_done && r_err;
  assign o_mem_address    = r_addr;
  assign o_mem_chipselect = r_cs;
  assign o_mem_write      = 1'b0;
  assign o_mem_byteenable = 4'hF;
  assign o_mem_clken      = 1'b1;
  always_ff @(posedge i_clk) begin
    if (i_reset || w_flush) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_left     <= '0;
      r_cs       <= 1'b0;
      r_cs_last  <= 1'b0;
      r_fly      <= 1'b0;
      r_fly_last <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_fly      <= r_cs;
      r_fly_last <= r_cs_last;
      case (r_state)
        S_IDLE:
          if (i_start && (i_num_words == '0 || w_bad)) begin
            r_state <= S_FIN;
            r_err   <= i_num_words != '0;
          end else if (i_start) begin
            r_state   <= S_RUN;
            r_cs      <= 1'b1;
            r_addr    <= i_base_addr;
            r_left    <= i_num_words - 1'b1;
            r_cs_last <= i_num_words == LEN_W'(1);
          end
        S_RUN:
          if (r_left == '0) begin
            r_state   <= S_DRAIN;
            r_cs      <= 1'b0;
            r_cs_last <= 1'b0;
          end else begin
            r_cs      <= w_credit;
            r_cs_last <= w_credit && r_left == LEN_W'(1);
            r_addr    <= w_credit ? r_addr + 1'b1 : r_addr;
            r_left    <= w_credit ? r_left - 1'b1 : r_left;
          end
        S_DRAIN:
          if (w_occ == 0) r_state <= S_FIN;
        default: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
      endcase
    end
  end
  nios_wallet_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (w_flush),
    .i_push  (r_fly),
    .i_data  ({r_fly_last, i_mem_readdata}),
    .i_pop   (w_pop),
    .o_data  ({o_out_last, o_out_data}),
    .o_valid (o_out_valid),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_nios_wallet_mem_stream_reader.sv
// tb_nios_wallet_mem_stream_reader: directed and random transfers checked against a word-queue model of the RAM range
module tb_nios_wallet_mem_stream_reader;
  logic clk = 0;
  logic i_reset = 1, i_start = 0, i_abort = 0, i_out_ready = 0;
  logic [12:0] i_base_addr = '0;
  logic [13:0] i_num_words = '0;
  logic [31:0] i_mem_readdata;
  logic o_busy, o_done, o_err, o_mem_chipselect, o_mem_write, o_mem_clken, o_out_valid, o_out_last;
  logic [12:0] o_mem_address;
  logic [3:0] o_mem_byteenable;
  logic [31:0] o_out_data;
  logic [31:0] ram [6500];
  logic [32:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0;
  int mode = 0, cur_base = 0, cs_tot = 0, hs_tot = 0, first_v = -1;
  int done_cyc = 0, done_cs = 0;
  logic done_seen = 0, done_err = 0;
  logic s_valid = 0, s_ready = 0, s_last = 0, s_busy = 0, s_done = 0, s_err = 0, s_cs = 0, s_fl = 0;
  logic [31:0] s_data = '0;
  logic [12:0] s_addr = '0;
  logic p_valid, p_ready, p_last, p_fl;
  logic [31:0] p_data;

  nios_wallet_mem_stream_reader dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_num_words(i_num_words),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_mem_address(o_mem_address), .o_mem_chipselect(o_mem_chipselect),
    .o_mem_write(o_mem_write), .o_mem_byteenable(o_mem_byteenable), .o_mem_clken(o_mem_clken),
    .i_mem_readdata(i_mem_readdata),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .o_out_last(o_out_last),
    .i_out_ready(i_out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) i_mem_readdata <= o_mem_chipselect ? ram[o_mem_address] : $urandom;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: sample outputs at the falling edge, score the stream, then drive ready
  task automatic tick();
    @(negedge clk);
    p_valid = s_valid; p_ready = s_ready; p_last = s_last; p_data = s_data; p_fl = s_fl;
    s_valid = o_out_valid; s_ready = i_out_ready; s_last = o_out_last; s_data = o_out_data;
    s_busy = o_busy; s_done = o_done; s_err = o_err; s_cs = o_mem_chipselect; s_addr = o_mem_address;
    s_fl = i_abort | i_reset;
    if (p_valid && !p_ready && !p_fl) begin
      chk("hold_valid", 64'(s_valid), 64'(1));
      chk("hold_word", 64'({s_last, s_data}), 64'({p_last, p_data}));
    end
    if (!s_busy) begin cs_tot = 0; hs_tot = 0; end
    if (s_cs) begin
      chk("mem_addr", 64'(s_addr), 64'(cur_base + cs_tot));
      cs_tot++;
      chk("credit_bound", 64'(cs_tot - hs_tot <= 4), 64'(1));
    end
    if (s_valid && first_v < 0) first_v = cyc;
    if (s_valid && s_ready) begin
      hs_tot++;
      chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("stream_word", 64'({s_last, s_data}), 64'(exp_q.pop_front()));
    end
    if (s_done) begin done_seen = 1; done_cyc = cyc; done_err = s_err; done_cs = cs_tot; end
    @(posedge clk);
    #1;
    i_out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~i_out_ready : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(s_busy), 64'(0));
    chk({tag, "_done"}, 64'(s_done), 64'(0));
    chk({tag, "_err"}, 64'(s_err), 64'(0));
    chk({tag, "_valid"}, 64'(s_valid), 64'(0));
    chk({tag, "_last"}, 64'(s_last), 64'(0));
    chk({tag, "_data"}, 64'(s_data), 64'(0));
    chk({tag, "_cs"}, 64'(s_cs), 64'(0));
    chk({tag, "_addr"}, 64'(s_addr), 64'(0));
  endtask

  task automatic launch(input int base, input int n, input int m);
    mode = m;
    i_out_ready = m == 0 || m == 1;
    cur_base = base;
    exp_q.delete();
    if (n != 0 && base + n <= 6500)
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, ram[base + i]});
    done_seen = 0; first_v = -1;
    i_base_addr = 13'(base); i_num_words = 14'(n); i_start = 1;
  endtask

  task automatic go(input string tag, input int base, input int n, input int m, input int spur_at);
    int t0;
    logic bad;
    bad = n != 0 && base + n > 6500;
    launch(base, n, m);
    t0 = cyc;
    tick();
    i_start = 0;
    for (int k = 0; k < 600 && !done_seen; k++) begin
      if (k == spur_at) begin i_start = 1; i_base_addr = 13'd500; i_num_words = 14'd3; end
      tick();
      i_start = 0;
    end
    chk({tag, "_done_seen"}, 64'(done_seen), 64'(1));
    chk({tag, "_err"}, 64'(done_err), 64'(bad));
    chk({tag, "_reads"}, 64'(done_cs), 64'(bad ? 0 : n));
    chk({tag, "_left"}, 64'(exp_q.size()), 64'(0));
    if (n == 0 || bad) chk({tag, "_lat"}, 64'(done_cyc - t0), 64'(1));
    else if (m == 0) begin
      chk({tag, "_first_valid"}, 64'(first_v - t0), 64'(3));
      chk({tag, "_lat"}, 64'(done_cyc - t0), 64'(n + 3));
    end
    tick();
    chk({tag, "_busy_fall"}, 64'(s_busy), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 6500; i++) ram[i] = $urandom;
    for (int i = 0; i < 4; i++) ram[i] = 32'h11111111 * 32'(i);
    tick(); tick();
    chk_idle("reset");
    chk("tie_write", 64'(o_mem_write), 64'(0));
    chk("tie_be", 64'(o_mem_byteenable), 64'(4'hF));
    chk("tie_clken", 64'(o_mem_clken), 64'(1));
    i_reset = 0;
    tick();
    go("basic", 0, 4, 0, -1);
    go("toggle", 100, 8, 1, -1);
    go("zero", 40, 0, 0, -1);
    go("reject", 6499, 2, 0, -1);
    go("top_edge", 6496, 4, 0, -1);
    // abort with the output buffer full and the consumer stalled
    launch(200, 20, 3);
    tick();
    i_start = 0;
    repeat (8) tick();
    chk("abort_pre_busy", 64'(s_busy), 64'(1));
    chk("abort_pre_valid", 64'(s_valid), 64'(1));
    i_abort = 1;
    tick();
    i_abort = 0;
    exp_q.delete();
    tick();
    chk("abort_busy", 64'(s_busy), 64'(0));
    chk("abort_valid", 64'(s_valid), 64'(0));
    chk("abort_no_done", 64'(done_seen), 64'(0));
    go("after_abort", 8, 1, 0, -1);
    go("spurious_start", 300, 10, 2, 3);
    // reset while draining a stalled transfer
    launch(50, 3, 3);
    tick();
    i_start = 0;
    repeat (6) tick();
    chk("drain_busy", 64'(s_busy), 64'(1));
    i_reset = 1;
    tick();
    i_reset = 0;
    exp_q.delete();
    tick();
    chk_idle("reset_drain");
    for (int r = 0; r < 8; r++) begin
      int b, n;
      b = $urandom_range(0, 6450);
      n = $urandom_range(1, 30);
      go("random", b, n, 2, -1);
    end
    go("random_reject", 6490, $urandom_range(11, 40), 2, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
